// File: rtl/mvm_feed_sched.sv
// Feed sequencer for the MVM datapath: walks wout -> height -> win, issues paired buffer reads,
// aligns valids to buffer latency and counts result beats. Optional perf counters: MVM_SCHED_PERF_EN.
module mvm_feed_sched #(
    parameter int DAT_AW   = 12,
    parameter int WT_AW    = 12,
    parameter int RD_LAT   = 1,
    parameter int HEIGHT_W = 8,
    parameter int WDIV_W   = 6,
    parameter int SHIFT_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [HEIGHT_W-1:0] cfg_height,
    input  logic [WDIV_W-1:0]   cfg_win_div_tin,
    input  logic [WDIV_W-1:0]   cfg_wout_div_tout,
    input  logic [SHIFT_W-1:0]  cfg_shift,
    input  logic                stall,
    output logic                dat_rd_en,
    output logic [DAT_AW-1:0]   dat_rd_addr,
    output logic                wt_rd_en,
    output logic [WT_AW-1:0]    wt_rd_addr,
    output logic                mvm_dat_vld,
    output logic                mvm_wt_vld,
    output logic [HEIGHT_W-1:0] mvm_height,
    output logic [WDIV_W-1:0]   mvm_win_div_tin,
    output logic [WDIV_W-1:0]   mvm_wout_div_tout,
    output logic [SHIFT_W-1:0]  mvm_shift,
    input  logic                mvm_out_vld,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
`ifdef MVM_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_cycles,
    output logic [31:0]         perf_stalls
`endif
);

    localparam int BW = HEIGHT_W + WDIV_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t                state_reg, state_next;
    logic [HEIGHT_W-1:0]   height_reg;
    logic [WDIV_W-1:0]     win_div_reg, wout_div_reg;
    logic [SHIFT_W-1:0]    shift_reg;
    logic [WDIV_W-1:0]     win_reg, wo_reg;
    logic [HEIGHT_W-1:0]   h_reg;
    logic [DAT_AW-1:0]     hbase_reg;
    logic [WT_AW-1:0]      wbase_reg;
    logic [BW-1:0]         beat_reg, exp_reg, beat_next;
    logic                  cfg_err_reg;
    logic [RD_LAT-1:0]     vld_sr;

    logic start_ok, cfg_zero, issue, win_last, h_last, wo_last, beats_done;

    assign start_ok = (state_reg == IDLE) && start;
    assign cfg_zero = (cfg_height == '0) || (cfg_win_div_tin == '0) ||
                      (cfg_wout_div_tout == '0) || (cfg_shift == '0);
    assign issue    = (state_reg == ISSUE) && !stall;
    assign win_last = (win_reg == win_div_reg - WDIV_W'(1));
    assign h_last   = (h_reg == height_reg - HEIGHT_W'(1));
    assign wo_last  = (wo_reg == wout_div_reg - WDIV_W'(1));

    // Beats beyond the expected total are absorbed by saturating the count.
    always_comb begin
        beat_next = beat_reg + BW'(mvm_out_vld);
        if (beat_next > exp_reg)
            beat_next = exp_reg;
    end
    assign beats_done = (beat_next == exp_reg);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        dat_rd_en   = 1'b0;
        wt_rd_en    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        dat_rd_addr = hbase_reg + DAT_AW'(win_reg);
        wt_rd_addr  = wbase_reg + WT_AW'(win_reg);
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = cfg_zero ? FIN : ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                dat_rd_en = issue;
                wt_rd_en  = issue;
                if (issue && win_last && h_last && wo_last)
                    state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (beats_done)
                    state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            height_reg   <= '0;
            win_div_reg  <= '0;
            wout_div_reg <= '0;
            shift_reg    <= '0;
            win_reg      <= '0;
            h_reg        <= '0;
            wo_reg       <= '0;
            hbase_reg    <= '0;
            wbase_reg    <= '0;
            beat_reg     <= '0;
            exp_reg      <= '0;
            cfg_err_reg  <= 1'b0;
        end else if (start_ok) begin
            height_reg   <= cfg_height;
            win_div_reg  <= cfg_win_div_tin;
            wout_div_reg <= cfg_wout_div_tout;
            shift_reg    <= cfg_shift;
            win_reg      <= '0;
            h_reg        <= '0;
            wo_reg       <= '0;
            hbase_reg    <= '0;
            wbase_reg    <= '0;
            beat_reg     <= '0;
            exp_reg      <= BW'(cfg_height) * BW'(cfg_wout_div_tout);
            cfg_err_reg  <= cfg_zero;
        end else begin
            // Running bases replace h*W and wo*W products.
            if (issue) begin
                if (win_last) begin
                    win_reg <= '0;
                    if (h_last) begin
                        h_reg     <= '0;
                        hbase_reg <= '0;
                        wo_reg    <= wo_reg + WDIV_W'(1);
                        wbase_reg <= wbase_reg + WT_AW'(win_div_reg);
                    end else begin
                        h_reg     <= h_reg + HEIGHT_W'(1);
                        hbase_reg <= hbase_reg + DAT_AW'(win_div_reg);
                    end
                end else begin
                    win_reg <= win_reg + WDIV_W'(1);
                end
            end
            if ((state_reg == ISSUE || state_reg == DRAIN) && mvm_out_vld)
                beat_reg <= beat_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_vld
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n)
                        vld_sr[gi] <= 1'b0;
                    else
                        vld_sr[gi] <= issue;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst_n)
                        vld_sr[gi] <= 1'b0;
                    else
                        vld_sr[gi] <= vld_sr[gi-1];
                end
            end
        end
    endgenerate

    assign mvm_dat_vld       = vld_sr[RD_LAT-1];
    assign mvm_wt_vld        = vld_sr[RD_LAT-1];
    assign mvm_height        = height_reg;
    assign mvm_win_div_tin   = win_div_reg;
    assign mvm_wout_div_tout = wout_div_reg;
    assign mvm_shift         = shift_reg;
    assign cfg_err           = cfg_err_reg;

`ifdef MVM_SCHED_PERF_EN
    logic [31:0] perf_cycles_reg, perf_stalls_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            perf_cycles_reg <= '0;
            perf_stalls_reg <= '0;
        end else begin
            if (busy && perf_cycles_reg != '1)
                perf_cycles_reg <= perf_cycles_reg + 32'd1;
            if (state_reg == ISSUE && stall && perf_stalls_reg != '1)
                perf_stalls_reg <= perf_stalls_reg + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_reg;
    assign perf_stalls = perf_stalls_reg;
`endif

endmodule

// File: tb/tb_mvm_feed_sched.sv
// Bench for mvm_feed_sched: table of layer configs plus randomized layers, checked against a
// loop-nest address model; separate RD_LAT=3 instance for the latency case.
module tb_mvm_feed_sched;

    localparam int AW = 12;
    localparam int HW = 8;
    localparam int WD = 6;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, start3 = 1'b0, stall = 1'b0, out_vld = 1'b0, out_vld3 = 1'b0;
    logic [HW-1:0] cfg_height = '0;
    logic [WD-1:0] cfg_win_div_tin = '0, cfg_wout_div_tout = '0;
    logic [SW-1:0] cfg_shift = '0;

    logic          dat_rd_en, wt_rd_en, mvm_dat_vld, mvm_wt_vld, busy, done, cfg_err;
    logic [AW-1:0] dat_rd_addr, wt_rd_addr;
    logic [HW-1:0] mvm_height;
    logic [WD-1:0] mvm_win_div_tin, mvm_wout_div_tout;
    logic [SW-1:0] mvm_shift;

    logic          d3_dat_rd_en, d3_wt_rd_en, d3_dat_vld, d3_wt_vld, d3_busy, d3_done, d3_cfg_err;
    logic [AW-1:0] d3_dat_rd_addr, d3_wt_rd_addr;
    logic [HW-1:0] d3_height;
    logic [WD-1:0] d3_win, d3_wout;
    logic [SW-1:0] d3_shift;
`ifdef MVM_SCHED_PERF_EN
    logic [31:0] perf_cycles, perf_stalls, d3_perf_cycles, d3_perf_stalls;
`endif

    always #5 clk = ~clk;

    mvm_feed_sched #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_height(cfg_height), .cfg_win_div_tin(cfg_win_div_tin),
        .cfg_wout_div_tout(cfg_wout_div_tout), .cfg_shift(cfg_shift), .stall(stall),
        .dat_rd_en(dat_rd_en), .dat_rd_addr(dat_rd_addr),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
        .mvm_dat_vld(mvm_dat_vld), .mvm_wt_vld(mvm_wt_vld),
        .mvm_height(mvm_height), .mvm_win_div_tin(mvm_win_div_tin),
        .mvm_wout_div_tout(mvm_wout_div_tout), .mvm_shift(mvm_shift),
        .mvm_out_vld(out_vld), .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef MVM_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    mvm_feed_sched #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .cfg_height(cfg_height), .cfg_win_div_tin(cfg_win_div_tin),
        .cfg_wout_div_tout(cfg_wout_div_tout), .cfg_shift(cfg_shift), .stall(1'b0),
        .dat_rd_en(d3_dat_rd_en), .dat_rd_addr(d3_dat_rd_addr),
        .wt_rd_en(d3_wt_rd_en), .wt_rd_addr(d3_wt_rd_addr),
        .mvm_dat_vld(d3_dat_vld), .mvm_wt_vld(d3_wt_vld),
        .mvm_height(d3_height), .mvm_win_div_tin(d3_win),
        .mvm_wout_div_tout(d3_wout), .mvm_shift(d3_shift),
        .mvm_out_vld(out_vld3), .busy(d3_busy), .done(d3_done), .cfg_err(d3_cfg_err)
`ifdef MVM_SCHED_PERF_EN
        , .perf_cycles(d3_perf_cycles), .perf_stalls(d3_perf_stalls)
`endif
    );

    typedef struct {
        int h;
        int w;
        int o;
        int sh;
        int mode;       // 0 plain, 1 stall window, 2 random stall, 3 start pokes while busy/FIN
        int exp_reads;
        bit exp_err;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dat_rd_en"}, dat_rd_en, 0);
        check({tag, "_wt_rd_en"}, wt_rd_en, 0);
        check({tag, "_dat_addr"}, dat_rd_addr, 0);
        check({tag, "_wt_addr"}, wt_rd_addr, 0);
        check({tag, "_vld"}, {mvm_dat_vld, mvm_wt_vld}, 0);
        check({tag, "_cfg_latch"}, {mvm_height, mvm_win_div_tin, mvm_wout_div_tout, mvm_shift}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // Drive one layer and check every cycle against the loop-nest model.
    task automatic run_layer(input vec_t v);
        int exp_dat[$];
        int exp_wt[$];
        int total, n_beats, rd_cnt, beats, last_rd, last_beat, stall_cnt, done_c, fin_c;
        bit prev_rd, exp_rd, exp_done;
        for (int wo = 0; wo < v.o; wo++)
            for (int hh = 0; hh < v.h; hh++)
                for (int x = 0; x < v.w; x++) begin
                    exp_dat.push_back((hh * v.w + x) % (1 << AW));
                    exp_wt.push_back((wo * v.w + x) % (1 << AW));
                end
        total   = v.exp_err ? 0 : v.exp_reads;
        n_beats = v.exp_err ? 0 : v.h * v.o;
        cfg_height        = HW'(v.h);
        cfg_win_div_tin   = WD'(v.w);
        cfg_wout_div_tout = WD'(v.o);
        cfg_shift         = SW'(v.sh);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rd_cnt = 0; beats = 0; last_rd = -1; last_beat = -1; stall_cnt = 0; done_c = -1;
        prev_rd = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            start   = 1'b0;
            stall   = 1'b0;
            out_vld = 1'b0;
            if (v.mode == 1)
                stall = (c >= 3 && c <= 5);
            else if (v.mode == 2)
                stall = (rd_cnt < total) && ($urandom_range(0, 3) == 0);
            if (v.mode == 3 && c == 2) begin
                start             = 1'b1;
                cfg_height        = HW'(v.h + 1);
                cfg_win_div_tin   = WD'(v.w + 1);
                cfg_wout_div_tout = WD'(v.o + 1);
                cfg_shift         = SW'(v.sh + 1);
            end
            if (!v.exp_err && beats < n_beats && rd_cnt > 0 && $urandom_range(0, 2) == 0)
                out_vld = 1'b1;
            if (stall)
                stall_cnt++;
            @(negedge clk);
            if (c == 0) begin
                check("cfg_err_after_start", cfg_err, v.exp_err);
                check("mvm_height", mvm_height, v.h % (1 << HW));
                check("mvm_win_div_tin", mvm_win_div_tin, v.w % (1 << WD));
                check("mvm_wout_div_tout", mvm_wout_div_tout, v.o % (1 << WD));
                check("mvm_shift", mvm_shift, v.sh % (1 << SW));
            end
            exp_rd = (rd_cnt < total) && !stall;
            check("dat_rd_en", dat_rd_en, exp_rd);
            check("wt_rd_en", wt_rd_en, exp_rd);
            if (dat_rd_en && rd_cnt < exp_dat.size()) begin
                check("dat_rd_addr", dat_rd_addr, exp_dat[rd_cnt]);
                check("wt_rd_addr", wt_rd_addr, exp_wt[rd_cnt]);
                rd_cnt++;
                last_rd = c;
            end
            check("mvm_dat_vld", mvm_dat_vld, prev_rd);
            check("mvm_wt_vld", mvm_wt_vld, prev_rd);
            prev_rd = dat_rd_en;
            if (out_vld) begin
                beats++;
                last_beat = c;
            end
            if (v.exp_err) begin
                exp_done = done;
                if (done)
                    check("err_done_latency_ok", (c <= 1), 1);
            end else begin
                fin_c    = ((last_rd + 1 > last_beat) ? last_rd + 1 : last_beat) + 1;
                exp_done = (rd_cnt == total) && (beats == n_beats) && (c == fin_c);
                check("done", done, exp_done);
            end
            check("busy", busy, !v.exp_err && !exp_done);
            if (done) begin
                done_c = c;
                check("cfg_kept_height", mvm_height, v.h % (1 << HW));
                check("cfg_kept_win", mvm_win_div_tin, v.w % (1 << WD));
                check("reads_total", rd_cnt, total);
`ifdef MVM_SCHED_PERF_EN
                check("perf_cycles", perf_cycles, v.exp_err ? 0 : c);
                check("perf_stalls", perf_stalls, stall_cnt);
`endif
                if (v.mode == 3)
                    start = 1'b1;
                break;
            end
            if (v.exp_err && c >= 2)
                break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start   = 1'b0;
        stall   = 1'b0;
        out_vld = 1'b0;
        if (done_c < 0) begin
            check("done_seen_in_budget", 0, 1);
        end else begin
            @(negedge clk);
            check("post_done_busy", busy, 0);
            check("post_done_done", done, 0);
            check("post_done_rd_en", dat_rd_en, 0);
            check("post_done_cfg_err", cfg_err, v.exp_err);
`ifdef MVM_SCHED_PERF_EN
            check("perf_cycles_hold", perf_cycles, v.exp_err ? 0 : done_c);
            check("perf_stalls_hold", perf_stalls, stall_cnt);
`endif
            @(posedge clk); #1;
        end
        $display("layer h=%0d w=%0d o=%0d mode=%0d reads=%0d beats=%0d done_cycle=%0d",
                 v.h, v.w, v.o, v.mode, rd_cnt, beats, done_c);
    endtask

    // Reset asserted right after the 5th read of a 2x3x2 layer.
    task automatic reset_mid();
        int n;
        cfg_height = 8'd2; cfg_win_div_tin = 6'd3; cfg_wout_div_tout = 6'd2; cfg_shift = 5'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dat_rd_en) begin
                check("rstmid_dat_addr", dat_rd_addr, n);
                n++;
            end
            if (n == 5) begin
                rst_n = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        check("rstmid_reads_before_reset", n, 5);
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("rstmid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rstmid_no_done", done, 0);
            check("rstmid_no_read", dat_rd_en, 0);
            @(posedge clk); #1;
        end
        $display("reset mid-issue after %0d reads", n);
    endtask

    // RD_LAT=3 instance, single-triple layer.
    task automatic run_lat3();
        int busy_cnt, done_c;
        cfg_height = 8'd1; cfg_win_div_tin = 6'd1; cfg_wout_div_tout = 6'd1; cfg_shift = 5'd3;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        busy_cnt = 0;
        done_c = -1;
        for (int c = 0; c < 20; c++) begin
            out_vld3 = (c == 4);
            @(negedge clk);
            check("lat3_rd_en", d3_dat_rd_en && d3_wt_rd_en, (c == 0));
            if (c == 0)
                check("lat3_addr", {d3_dat_rd_addr, d3_wt_rd_addr}, 0);
            check("lat3_vld", d3_dat_vld && d3_wt_vld, (c == 3));
            check("lat3_done", d3_done, (c == 5));
            if (d3_busy)
                busy_cnt++;
            if (d3_done) begin
                done_c = c;
`ifdef MVM_SCHED_PERF_EN
                check("lat3_perf_cycles", d3_perf_cycles, busy_cnt);
                check("lat3_perf_stalls", d3_perf_stalls, 0);
`endif
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        out_vld3 = 1'b0;
        check("lat3_done_seen", (done_c >= 0), 1);
        check("lat3_busy_cycles", busy_cnt, 5);
        $display("lat3 layer busy_cycles=%0d done_cycle=%0d", busy_cnt, done_c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t rv;
        tbl[0] = '{2, 3, 2, 7, 0, 12, 1'b0};
        tbl[1] = '{2, 3, 2, 7, 1, 12, 1'b0};
        tbl[2] = '{2, 3, 0, 7, 0, 0, 1'b1};
        tbl[3] = '{2, 3, 2, 9, 3, 12, 1'b0};
        tbl[4] = '{1, 1, 1, 1, 0, 1, 1'b0};
        tbl[5] = '{0, 2, 2, 4, 0, 0, 1'b1};
        tbl[6] = '{3, 2, 4, 4, 0, 24, 1'b0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("reset");
        check("reset_d3_busy", d3_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            run_layer(tbl[i]);

        reset_mid();
        run_layer(tbl[0]);
        run_lat3();

        for (int i = 0; i < 8; i++) begin
            rv.h = $urandom_range(1, 4);
            rv.w = $urandom_range(1, 4);
            rv.o = $urandom_range(1, 3);
            rv.sh = $urandom_range(1, 31);
            rv.mode = 2;
            rv.exp_reads = rv.h * rv.w * rv.o;
            rv.exp_err = 1'b0;
            run_layer(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
